pc_unit: RTL

- Parametrised next-generation program counter for the pipelined MIPS core. Sits at the head of the IF stage and drives the instruction memory address.
- Adds four features over a plain enabled PC register:
  - synchronous reset to a configurable vector
  - internal next-PC selection: increment, branch, jump, call, return, exception
  - a circular return-address stack (RAS) for call/return prediction
  - misaligned-target detection

---
 rtl/pc_pkg.sv | 24 ++
 rtl/return_address_stack.sv | 75 +++++++
 rtl/pc_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the IF-stage program counter: next-PC select codes,
// default reset/exception vectors and the alignment helper.
// Pure declarations; no timing or flow-control behaviour.
package pc_pkg;

  // Next-PC source chosen by the priority encoder in pc_unit
  typedef enum logic [2:0] {
    SEL_INC  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_RET  = 3'd3,
    SEL_EXC  = 3'd4,
    SEL_HOLD = 3'd5
  } pc_sel_e;

  localparam logic [31:0] PC_DEFAULT_RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] PC_DEFAULT_EXC_ADDR   = 32'h0000_0080;

  // Instruction words are 4-byte aligned; any low bit set is a bad target
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full.
// Latency: top/count reflect a push or pop one cycle after it is sampled.
// No backpressure: push when full overwrites, pop when empty is ignored.
module return_address_stack #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_WIDTH-1:0]          push_data,
  output logic [ADDR_WIDTH-1:0]          top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count,
  output logic                           empty,
  output logic                           full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH+1);

  // sp_q points at the next free slot; the top entry sits just below it.
  // Because the depth is a power of two the pointer wraps for free, which
  // is what makes a push-when-full land on the oldest entry.
  logic [PTR_W-1:0]      sp_q, sp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_q [RAS_DEPTH];
  logic                  wr_en;
  logic [PTR_W-1:0]      wr_idx;
  logic [PTR_W-1:0]      top_idx;

  assign top_idx = sp_q - PTR_W'(1);
  assign top     = mem_q[top_idx];
  assign count   = cnt_q;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(RAS_DEPTH));

  // Pointer/count update; simultaneous push+pop on a non-empty stack
  // replaces the top in place rather than moving the pointer twice
  always_comb begin
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = sp_q;
    if (push && pop && !empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      wr_en  = 1'b1;
      wr_idx = sp_q;
      sp_d   = sp_q + PTR_W'(1);
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      sp_d  = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are meaningless after reset so not cleared
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter with next-PC select, return-address stack and alignment check.
// Latency: selected target appears on pc_out one cycle after inputs are sampled.
// enable=0 stalls PC and RAS; exception is honoured regardless of enable.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(PC_DEFAULT_RESET_ADDR),
  parameter logic [ADDR_WIDTH-1:0] EXC_ADDR   = ADDR_WIDTH'(PC_DEFAULT_EXC_ADDR),
  parameter int unsigned           INC        = 4,
  parameter int unsigned           RAS_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           exception,
  input  logic                           branch_taken,
  input  logic [ADDR_WIDTH-1:0]          branch_target,
  input  logic                           jump,
  input  logic                           call,
  input  logic [ADDR_WIDTH-1:0]          jump_target,
  input  logic                           ret,
  input  logic [ADDR_WIDTH-1:0]          ret_target,
  output logic [ADDR_WIDTH-1:0]          pc_out,
  output logic [ADDR_WIDTH-1:0]          pc_plus_inc,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           misalign_err
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  misalign_q, misalign_d;
  pc_sel_e               sel;
  logic [ADDR_WIDTH-1:0] raw_target;
  logic                  check_align;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic                  ras_push, ras_pop;

  assign pc_out       = pc_q;
  assign pc_plus_inc  = pc_q + ADDR_WIDTH'(INC);
  assign misalign_err = misalign_q;

  // The stack only moves on an unstalled, non-exception cycle
  assign ras_push = enable && !exception && call;
  assign ras_pop  = enable && !exception && ret;

  return_address_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAS_DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus_inc),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // Priority encoder: exception > stall > ret > call/jump > branch > increment
  always_comb begin
    sel = SEL_INC;
    if (exception)              sel = SEL_EXC;
    else if (!enable)           sel = SEL_HOLD;
    else if (ret)               sel = SEL_RET;
    else if (call || jump)      sel = SEL_JMP;
    else if (branch_taken)      sel = SEL_BR;
  end

  // Target mux; ret uses the pre-update RAS top even when call also fires
  always_comb begin
    raw_target  = pc_plus_inc;
    check_align = 1'b0;
    unique case (sel)
      SEL_EXC:  raw_target = EXC_ADDR;
      SEL_HOLD: raw_target = pc_q;
      SEL_RET: begin
        raw_target  = ras_empty ? ret_target : ras_top;
        check_align = 1'b1;
      end
      SEL_JMP: begin
        raw_target  = jump_target;
        check_align = 1'b1;
      end
      SEL_BR: begin
        raw_target  = branch_target;
        check_align = 1'b1;
      end
      default:  raw_target = pc_plus_inc;
    endcase
  end

  // Redirect targets are word-aligned by clearing the low bits and flagged;
  // increment, hold and the exception vector pass through untouched
  always_comb begin
    pc_d       = raw_target;
    misalign_d = 1'b0;
    if (check_align) begin
      pc_d       = {raw_target[ADDR_WIDTH-1:2], 2'b00};
      misalign_d = is_misaligned(raw_target[1:0]);
    end
  end

  // PC register and one-cycle misalignment pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_ADDR;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
